// File: rtl/snn_input_loader_if.sv
// ---------------------------------------------------------------------------
// snn_input_loader_if
//  Bundles the byte stream, the core-side pixel read port, the core
//  handshake and the status outputs of snn_input_loader.
//  master : the environment (byte source + snn_core) driving the loader
//  slave  : snn_input_loader itself
//  Signals:
//   rx_data/rx_valid        image byte stream (one-cycle strobe per byte)
//   addr_input_unit/q_input pixel read port, one-cycle read latency
//   start/done/digit        handshake with snn_core
//   result_digit/valid      captured classification
//   busy/rx_drop            status
// ---------------------------------------------------------------------------
interface snn_input_loader_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [9:0] addr_input_unit;
  logic       q_input;
  logic       start;
  logic       done;
  logic [3:0] digit;
  logic [3:0] result_digit;
  logic       result_valid;
  logic       busy;
  logic       rx_drop;

  modport master (
    output rx_data, rx_valid, addr_input_unit, done, digit,
    input  q_input, start, result_digit, result_valid, busy, rx_drop
  );

  modport slave (
    input  rx_data, rx_valid, addr_input_unit, done, digit,
    output q_input, start, result_digit, result_valid, busy, rx_drop
  );
endinterface

// File: rtl/snn_input_loader.sv
// ---------------------------------------------------------------------------
// snn_input_loader
//  Upstream stage of snn_core. Collects one binary image (NUM_PIXELS pixels,
//  8 pixels per byte) from a byte stream, then pulses start to the core and
//  serves pixels with one-cycle read latency while the core runs. When the
//  core reports done, the classified digit is captured and the loader
//  re-arms for the next image.
//  Ports:
//   clk  system clock, all logic on posedge
//   rst  synchronous active-high reset (image memory is not cleared)
//   bus  snn_input_loader_if.slave: byte stream, pixel read port, core
//        handshake, result and status outputs
// ---------------------------------------------------------------------------
module snn_input_loader #(
  parameter int NUM_PIXELS = 784
) (
  input  logic                 clk,
  input  logic                 rst,
  snn_input_loader_if.slave    bus
);

  localparam int NUM_BYTES = NUM_PIXELS / 8;
  localparam int CNT_W     = $clog2(NUM_BYTES);
  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);
  localparam logic [9:0]       ADDR_LIM  = 10'(NUM_PIXELS);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_LATCH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             q_input_q, q_input_d;
  logic             start_q, start_d;
  logic [3:0]       result_digit_q, result_digit_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;
  logic             rx_drop_q, rx_drop_d;
  logic             mem_we;

  logic [7:0]       mem [NUM_BYTES];

  logic [6:0]       rd_byte;
  logic [2:0]       rd_bit;

  assign rd_byte = bus.addr_input_unit[9:3];
  assign rd_bit  = bus.addr_input_unit[2:0];

  always_comb begin
    state_d        = state_q;
    byte_cnt_d     = byte_cnt_q;
    result_digit_d = result_digit_q;
    mem_we         = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (bus.rx_valid) begin
          mem_we = 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = S_START;
          end else begin
            byte_cnt_d = byte_cnt_q + CNT_W'(1);
          end
        end
      end
      S_START: state_d = S_RUN;
      S_RUN: begin
        if (bus.done) state_d = S_LATCH;
      end
      S_LATCH: begin
        // The core's digit settles the cycle after done, i.e. while here.
        result_digit_d = bus.digit;
        state_d        = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase

    // Registered outputs computed from the upcoming state so they line up
    // with the state they describe.
    start_d        = (state_d == S_START);
    // Busy stays high through the result_valid cycle that follows LATCH.
    busy_d         = (state_d != S_LOAD) || (state_q == S_LATCH);
    result_valid_d = (state_q == S_LATCH);
    rx_drop_d      = bus.rx_valid && (state_q != S_LOAD);

    // addr < NUM_PIXELS guarantees rd_byte stays inside the memory.
    q_input_d = 1'b0;
    if (bus.addr_input_unit < ADDR_LIM) q_input_d = mem[rd_byte][rd_bit];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_LOAD;
      byte_cnt_q     <= '0;
      q_input_q      <= 1'b0;
      start_q        <= 1'b0;
      result_digit_q <= 4'd0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      rx_drop_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      byte_cnt_q     <= byte_cnt_d;
      q_input_q      <= q_input_d;
      start_q        <= start_d;
      result_digit_q <= result_digit_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
      rx_drop_q      <= rx_drop_d;
    end
  end

  // Image memory: never reset; a byte arriving under reset is not stored.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[byte_cnt_q] <= bus.rx_data;
  end

  assign bus.q_input      = q_input_q;
  assign bus.start        = start_q;
  assign bus.result_digit = result_digit_q;
  assign bus.result_valid = result_valid_q;
  assign bus.busy         = busy_q;
  assign bus.rx_drop      = rx_drop_q;

endmodule

// File: tb/tb_snn_input_loader.sv
// ---------------------------------------------------------------------------
// tb_snn_input_loader
//  Scoreboard bench for snn_input_loader: expected pixels and expected
//  digits are queued when stimulus is driven and compared when the loader
//  produces them.
// ---------------------------------------------------------------------------
module tb_snn_input_loader;

  logic clk;
  logic rst;

  snn_input_loader_if bif ();

  snn_input_loader #(.NUM_PIXELS(784)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int start_cnt = 0;
  int drop_cnt  = 0;
  int exp_starts = 0;
  int exp_drops  = 0;

  logic [7:0] img [98];
  logic       rdq [$];
  logic [3:0] digq [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pat(input int kind, input int k);
    case (kind)
      0:       pat = 8'hFF;
      1:       pat = 8'(k);
      2:       pat = 8'(k) ^ 8'h5A;
      default: pat = 8'(k * 37 + 11);
    endcase
  endfunction

  // Monitor: counts pulses and checks each result against the digit queue.
  always @(negedge clk) begin
    if (bif.start === 1'b1) start_cnt++;
    if (bif.rx_drop === 1'b1) drop_cnt++;
    if (bif.result_valid === 1'b1) begin
      if (digq.size() == 0) check("rv_unexpected", 1, 0);
      else check("sb_digit", {28'd0, bif.result_digit}, {28'd0, digq.pop_front()});
    end
  end

  task automatic send_bytes(input int kind, input int n, input bit completes);
    logic [7:0] b;
    for (int k = 0; k < n; k++) begin
      b = pat(kind, k);
      img[k] = b;
      bif.rx_data  = b;
      bif.rx_valid = 1'b1;
      tick();
      check("start_timing", {31'd0, bif.start}, {31'd0, (completes && k == n - 1)});
    end
    bif.rx_valid = 1'b0;
    if (completes) begin
      exp_starts++;
      check("busy_at_start", {31'd0, bif.busy}, 1);
      tick();
      check("start_one_cycle", {31'd0, bif.start}, 0);
      check("busy_run", {31'd0, bif.busy}, 1);
    end
  endtask

  task automatic read_check(input int a);
    logic [9:0] av;
    av = 10'(a);
    rdq.push_back((a < 784) ? img[a >> 3][a % 8] : 1'b0);
    bif.addr_input_unit = av;
    tick();
    check("q_input", {31'd0, bif.q_input}, {31'd0, rdq.pop_front()});
  endtask

  task automatic read_all();
    for (int a = 0; a < 784; a++) read_check(a);
    read_check(784);
    read_check(800);
    read_check(1023);
  endtask

  task automatic finish_run(input logic [3:0] d_early, input logic [3:0] d_settled, input bit b2b);
    bif.digit = d_early;
    bif.done  = 1'b1;
    tick();
    bif.done  = 1'b0;
    bif.digit = d_settled;
    digq.push_back(d_settled);
    check("rv_at_d1", {31'd0, bif.result_valid}, 0);
    tick();
    check("rv_at_d2", {31'd0, bif.result_valid}, 1);
    check("digit_at_d2", {28'd0, bif.result_digit}, {28'd0, d_settled});
    check("busy_at_d2", {31'd0, bif.busy}, 1);
    if (!b2b) begin
      tick();
      check("rv_single", {31'd0, bif.result_valid}, 0);
      check("busy_cleared", {31'd0, bif.busy}, 0);
      check("digit_held", {28'd0, bif.result_digit}, {28'd0, d_settled});
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, {31'd0, bif.start}, 0);
    check({tag, "_busy"}, {31'd0, bif.busy}, 0);
    check({tag, "_q"}, {31'd0, bif.q_input}, 0);
    check({tag, "_rv"}, {31'd0, bif.result_valid}, 0);
    check({tag, "_digit"}, {28'd0, bif.result_digit}, 0);
    check({tag, "_drop"}, {31'd0, bif.rx_drop}, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bif.rx_data = 8'd0;
    bif.rx_valid = 1'b0;
    bif.addr_input_unit = 10'd0;
    bif.done = 1'b0;
    bif.digit = 4'd0;
    repeat (3) tick();
    check_reset_outputs("rst");
    rst = 1'b0;
    tick();
    check_reset_outputs("post_rst");

    // 1: all-ones frame, every pixel reads 1
    send_bytes(0, 98, 1'b1);
    read_all();
    finish_run(4'd5, 4'd5, 1'b0);

    // 2: counting pattern
    send_bytes(1, 98, 1'b1);
    read_all();

    // 3: bytes arriving during RUN are dropped
    for (int i = 0; i < 3; i++) begin
      bif.rx_data  = 8'h00;
      bif.rx_valid = 1'b1;
      tick();
      bif.rx_valid = 1'b0;
      exp_drops++;
      check("drop_pulse", {31'd0, bif.rx_drop}, 1);
      tick();
      check("drop_single", {31'd0, bif.rx_drop}, 0);
    end
    read_all();

    // 4: done with digit 7 held
    finish_run(4'd7, 4'd7, 1'b0);
    check("drops_total", drop_cnt, exp_drops);

    // done outside RUN is ignored
    bif.done = 1'b1;
    bif.digit = 4'd2;
    tick();
    bif.done = 1'b0;
    tick();
    check("done_in_load_rv", {31'd0, bif.result_valid}, 0);
    check("done_in_load_busy", {31'd0, bif.busy}, 0);

    // 5: partial frame then reset; the next full frame starts exactly once
    send_bytes(2, 50, 1'b0);
    rst = 1'b1;
    tick();
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    send_bytes(3, 98, 1'b1);
    read_all();
    finish_run(4'd1, 4'd1, 1'b0);
    check("starts_t5", start_cnt, exp_starts);

    // 6: back-to-back frames; digit only settles the cycle after done
    send_bytes(2, 98, 1'b1);
    finish_run(4'hF, 4'd3, 1'b1);
    send_bytes(1, 98, 1'b1);
    read_all();
    finish_run(4'hE, 4'd9, 1'b0);
    check("starts_total", start_cnt, exp_starts);
    check("drops_final", drop_cnt, exp_drops);
    check("digq_empty", digq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
